rr_mux_arbiter: RTL and testbench

//  Parametrised N-channel, WIDTH-bit operand multiplexer with registered output and valid/ready handshake.
//  - Default mode: round-robin arbitration among requesting channels.
//  - Forced mode: passes one channel chosen by a select input, giving the same selection behaviour as the 16-bit 2:1 mux.
//  - Sits between register-file/ALU result sources and shared consumers (writeback bus, memory port).

---
 rtl/rr_mux_pkg.sv | 12 +
 rtl/rr_grant.sv | 38 +++
 rtl/rr_mux_arbiter.sv | 92 +++++++++
 tb/tb_rr_mux_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin operand multiplexer.
// Imported by the grant encoder and the top level.
package rr_mux_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NCH   = 4;

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Rotating-priority encoder: the first requester at or after ptr wins,
// wrapping past the last channel back to channel 0.
module rr_grant
  import rr_mux_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int SELW = sel_width(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] idx,
  output logic            any
);

  logic [SELW:0]   s;
  logic [SELW-1:0] c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    s     = '0;
    c     = '0;
    for (int k = 0; k < NCH; k++) begin
      s = {1'b0, ptr} + (SELW+1)'(k);
      if (s >= (SELW+1)'(NCH))
        s = s - (SELW+1)'(NCH);
      c = s[SELW-1:0];
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-channel operand mux with registered output and valid/ready handshake.
// Round-robin by default; force_en pins selection to force_sel.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int SELW  = sel_width(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  input  logic                 force_en,
  input  logic [SELW-1:0]      force_sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr;
  logic [NCH-1:0]   rr_gnt;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;
  logic [NCH-1:0]   f_gnt;
  logic             f_any;
  logic [NCH-1:0]   gnt;
  logic [SELW-1:0]  gidx;
  logic             gany;
  logic [WIDTH-1:0] gdata;
  logic             load;
  logic             take;

  rr_grant #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_grant (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (rr_gnt),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // out-of-range force_sel matches no channel, so it grants nothing
  always_comb begin
    f_gnt = '0;
    f_any = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (force_sel == SELW'(i) && in_valid[i]) begin
        f_gnt[i] = 1'b1;
        f_any    = 1'b1;
      end
    end
  end

  assign gnt  = force_en ? f_gnt : rr_gnt;
  assign gidx = force_en ? force_sel : rr_idx;
  assign gany = force_en ? f_any : rr_any;

  always_comb begin
    gdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i])
        gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign load     = ~out_valid | out_ready;
  assign take     = load & gany & ~rst;
  assign in_ready = (load & ~rst) ? gnt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= gdata;
      out_sel   <= gidx;
      if (!force_en)
        ptr <= (gidx == SELW'(NCH - 1)) ? '0 : gidx + SELW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: reference model checked every cycle plus
// directed literal expectations for each scenario.
`timescale 1ns/1ps
module tb_rr_mux_arbiter;

  localparam int W = 16;
  localparam int N = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_ready;
  logic           force_en = 1'b0;
  logic [SW-1:0]  force_sel = '0;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready = 1'b0;

  int total = 0;
  int bad = 0;

  int m_valid = 0;
  int m_data = 0;
  int m_sel = 0;
  int m_ptr = 0;

  rr_mux_arbiter #(.WIDTH(W), .NCH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int chan(input int g);
    return int'(in_data[g*W +: W]);
  endfunction

  // channel that must win right now, -1 if none
  function automatic int want_grant();
    if (force_en) begin
      if (int'(force_sel) < N && in_valid[force_sel])
        return int'(force_sel);
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_ptr + k) % N])
        return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int want_ready();
    int g;
    g = want_grant();
    if (rst) return 0;
    if (m_valid != 0 && !out_ready) return 0;
    if (g < 0) return 0;
    return 1 << g;
  endfunction

  always @(posedge clk or posedge rst) begin
    int g;
    if (rst) begin
      m_valid <= 0;
      m_data  <= 0;
      m_sel   <= 0;
      m_ptr   <= 0;
    end else begin
      g = want_grant();
      if ((m_valid == 0 || out_ready) && g >= 0) begin
        m_valid <= 1;
        m_data  <= chan(g);
        m_sel   <= g;
        if (!force_en)
          m_ptr <= (g + 1) % N;
      end else if (out_ready) begin
        m_valid <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model out_valid", int'(out_valid), m_valid);
    chk("model out_data", int'(out_data), m_data);
    chk("model out_sel", int'(out_sel), m_sel);
    chk("model in_ready", int'(in_ready), want_ready());
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  int seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < N; i++)
      set_ch(i, 16'(16'h1000 + i));
    in_valid = 4'b1111;
    #2;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_data", int'(out_data), 0);
    chk("reset out_sel", int'(out_sel), 0);
    chk("reset in_ready", int'(in_ready), 0);
    cyc();
    cyc();
    chk("reset held in_ready", int'(in_ready), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("first grant ch0", int'(in_ready), 4'b0001);

    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr out_sel", int'(out_sel), seq[i]);
      chk("rr out_data", int'(out_data), 16'h1000 + seq[i]);
      chk("rr out_valid", int'(out_valid), 1);
    end

    set_ch(1, 16'hA5A5);
    cyc();
    chk("bp word", int'(out_data), 16'hA5A5);
    chk("bp sel", int'(out_sel), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall data", int'(out_data), 16'hA5A5);
      chk("stall valid", int'(out_valid), 1);
      chk("stall in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("resume in_ready", int'(in_ready), 4'b0100);
    cyc();
    chk("resume valid", int'(out_valid), 1);
    chk("resume sel", int'(out_sel), 2);
    chk("resume data", int'(out_data), 16'h1002);

    force_en = 1'b1;
    force_sel = 2'd2;
    in_valid = 4'b0101;
    set_ch(2, 16'h1234);
    set_ch(0, 16'hFFFF);
    #1;
    chk("force in_ready", int'(in_ready), 4'b0100);
    cyc();
    chk("force data", int'(out_data), 16'h1234);
    chk("force sel", int'(out_sel), 2);
    force_sel = 2'd3;
    #1;
    chk("force idle in_ready", int'(in_ready), 0);
    cyc();
    chk("force idle valid", int'(out_valid), 0);
    chk("force idle data", int'(out_data), 16'h1234);
    chk("force ptr kept", m_ptr, 3);
    force_en = 1'b0;
    in_valid = 4'b1111;
    #1;
    chk("ptr3 in_ready", int'(in_ready), 4'b1000);
    in_valid = 4'b0010;
    set_ch(1, 16'h0001);
    #1;
    chk("sparse in_ready", int'(in_ready), 4'b0010);
    cyc();
    chk("sparse sel", int'(out_sel), 1);
    chk("sparse data", int'(out_data), 16'h0001);
    in_valid = 4'b1111;
    #1;
    chk("ptr2 in_ready", int'(in_ready), 4'b0100);

    in_valid = 4'b0001;
    set_ch(0, 16'h00FF);
    #1;
    chk("ch0 in_ready", int'(in_ready), 4'b0001);
    cyc();
    chk("hold data", int'(out_data), 16'h00FF);
    chk("hold valid", int'(out_valid), 1);
    out_ready = 1'b0;
    in_valid = 4'b0000;
    #1;
    rst = 1'b1;
    #1;
    chk("async rst valid", int'(out_valid), 0);
    chk("async rst data", int'(out_data), 0);
    chk("async rst in_ready", int'(in_ready), 0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("no re-emit", int'(out_valid), 0);
    end

    #10;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
